instr_encoder_loader: RTL and testbench

- Program loader for the single-cycle CPU bench. It accepts field-level instruction requests (class, registers, immediate) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I word covering the classes the control decoder recognises: R-type, addi, lw, sw, beq, jal, jalr.
- Writes the word into instruction memory at an auto-incrementing byte address.
- Acts as the inverse of opcode decoding: it produces the opcode/funct/immediate layouts that the decoder consumes.

---
 rtl/instr_enc_pkg.sv | 54 +++++
 rtl/instr_encode_comb.sv | 70 +++++++
 rtl/instr_encoder_loader.sv | 142 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I program loader: request classes, opcodes,
// fixed funct3 values and immediate range limits.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    OP_R    = 3'd0,
    OP_ADDI = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JAL  = 3'd5,
    OP_JALR = 3'd6,
    OP_LUI  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  typedef struct packed {
    op_e         op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instr_req_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -(1 << 20);
  localparam int IMM21_MAX = (1 << 20) - 2;

endpackage

// File: rtl/instr_encode_comb.sv
// Combinational field-to-word RV32I encoder with a legality flag.
// Op class 7 encodes lui only when ENC_UTYPE_EN is defined; otherwise it is illegal.
module instr_encode_comb
  import instr_enc_pkg::*;
(
  input  instr_req_t  req_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  logic signed [31:0] imm_s;
  logic               in12;
  logic               in13;
  logic               in21;

  assign imm_s = req_i.imm;
  assign in12  = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
  assign in13  = (imm_s >= IMM13_MIN) && (imm_s <= IMM13_MAX);
  assign in21  = (imm_s >= IMM21_MIN) && (imm_s <= IMM21_MAX);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    case (req_i.op)
      OP_R: begin
        word_o  = {1'b0, req_i.funct7b5, 5'b0, req_i.rs2, req_i.rs1,
                   req_i.funct3, req_i.rd, OPC_R};
        legal_o = 1'b1;
      end
      OP_ADDI: begin
        word_o  = {req_i.imm[11:0], req_i.rs1, F3_ADDI, req_i.rd, OPC_IMM};
        legal_o = in12;
      end
      OP_LW: begin
        word_o  = {req_i.imm[11:0], req_i.rs1, F3_LW, req_i.rd, OPC_LOAD};
        legal_o = in12;
      end
      OP_SW: begin
        word_o  = {req_i.imm[11:5], req_i.rs2, req_i.rs1, F3_SW,
                   req_i.imm[4:0], OPC_STORE};
        legal_o = in12;
      end
      OP_BEQ: begin
        // Branch and jump offsets are in halfwords, so bit 0 is never stored.
        word_o  = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1, F3_BEQ,
                   req_i.imm[4:1], req_i.imm[11], OPC_BRANCH};
        legal_o = in13 && !req_i.imm[0];
      end
      OP_JAL: begin
        word_o  = {req_i.imm[20], req_i.imm[10:1], req_i.imm[11],
                   req_i.imm[19:12], req_i.rd, OPC_JAL};
        legal_o = in21 && !req_i.imm[0];
      end
      OP_JALR: begin
        word_o  = {req_i.imm[11:0], req_i.rs1, F3_JALR, req_i.rd, OPC_JALR};
        legal_o = in12;
      end
      default: begin
`ifdef ENC_UTYPE_EN
        word_o  = {req_i.imm[31:12], req_i.rd, OPC_LUI};
        legal_o = (req_i.imm[11:0] == 12'h000);
`else
        word_o  = '0;
        legal_o = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field-level instruction requests, encodes them and
// writes them to instruction memory at an auto-incrementing address (lui via ENC_UTYPE_EN).
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        op_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7b5_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  output logic [ADDR_W:0]   count_o,
  output logic              err_o,
  output logic              wrap_o,
  output state_e            dbg_state_o
);

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; the memory write completes on an edge where
  // mem_we_o and mem_ack_i are both high, with addr/data held until then.
  state_e            state_q, state_d;
  instr_req_t        req_q, req_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;
  logic              clr_pend_q, clr_pend_d;
  logic [31:0]       enc_word;
  logic              enc_legal;

  instr_encode_comb u_enc (
    .req_i   (req_q),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wdata_d    = wdata_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    err_d      = err_q;
    wrap_d     = 1'b0;
    clr_pend_d = clr_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (req_valid_i) begin
          req_d.op       = op_e'(op_i);
          req_d.funct3   = funct3_i;
          req_d.funct7b5 = funct7b5_i;
          req_d.rd       = rd_i;
          req_d.rs1      = rs1_i;
          req_d.rs2      = rs2_i;
          req_d.imm      = imm_i;
          state_d        = ST_ENC;
        end
      end
      ST_ENC: begin
        state_d = ST_IDLE;
        if (clr_i) begin
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else if (enc_legal) begin
          wdata_d = enc_word;
          state_d = ST_WR;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_WR: begin
        // A clear during a write must not disturb addr/data, so it waits for the ack.
        if (clr_i) clr_pend_d = 1'b1;
        if (mem_ack_i) begin
          state_d    = ST_IDLE;
          clr_pend_d = 1'b0;
          if (clr_pend_q || clr_i) begin
            ptr_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
          end else begin
            ptr_d  = ptr_q + ADDR_W'(1);
            wrap_d = &ptr_q;
            if (count_q != '1) count_d = count_q + (ADDR_W+1)'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      wdata_q    <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wdata_q    <= wdata_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) && !clr_i;
  assign mem_we_o    = (state_q == ST_WR);
  assign mem_addr_o  = BASE_ADDR + (32'(ptr_q) << 2);
  assign mem_wdata_o = wdata_q;
  assign count_o     = count_q;
  assign err_o       = err_q;
  assign wrap_o      = wrap_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a memory responder doubles as the
// scoreboard monitor, popping expected {addr,data} pairs as writes complete.
module tb_instr_encoder_loader;
  import instr_enc_pkg::*;

  localparam int          ADDR_W  = 2;
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam int          CNT_MAX = (1 << (ADDR_W + 1)) - 1;
  localparam logic [31:0] BASE    = 32'h0000_0000;

  logic              clk;
  logic              rst_i;
  logic              clr_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        op_i;
  logic [2:0]        funct3_i;
  logic              funct7b5_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [31:0]       imm_i;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [ADDR_W:0]   count_o;
  logic              err_o;
  logic              wrap_o;
  state_e            dbg_state;

  logic [63:0] exp_q[$];
  int tests, fails;
  int exp_ptr, exp_count, exp_wraps, wraps_seen;
  int ack_delay, wait_cnt;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clr_i       (clr_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .op_i        (op_i),
    .funct3_i    (funct3_i),
    .funct7b5_i  (funct7b5_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .imm_i       (imm_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .count_o     (count_o),
    .err_o       (err_o),
    .wrap_o      (wrap_o),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder and scoreboard monitor
  initial begin
    wraps_seen = 0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        mem_ack_i = 1'b0;
        wait_cnt  = 0;
      end else begin
        if (wrap_o) wraps_seen++;
        if (mem_ack_i) begin
          mem_ack_i = 1'b0;
        end else if (mem_we_o) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                     mem_addr_o, mem_wdata_o);
          end else if ({mem_addr_o, mem_wdata_o} !== exp_q[0]) begin
            fails++;
            $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                     mem_addr_o, mem_wdata_o, exp_q[0][63:32], exp_q[0][31:0]);
          end
          if (wait_cnt >= ack_delay) begin
            mem_ack_i = 1'b1;
            wait_cnt  = 0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit legal, input logic [31:0] word);
    logic [31:0] addr;
    @(negedge clk);
    op_i = op; funct3_i = f3; funct7b5_i = f7;
    rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
    req_valid_i = 1'b1;
    for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk);
    if (!req_ready_o) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: ready 0 expected 1");
    end
    if (legal) begin
      addr = BASE + 32'(exp_ptr * 4);
      exp_q.push_back({addr, word});
      exp_ptr++;
      if (exp_ptr == DEPTH) begin
        exp_ptr = 0;
        exp_wraps++;
      end
      if (exp_count < CNT_MAX) exp_count++;
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready_o && !mem_we_o && dbg_state == ST_IDLE) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: pending %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_we(input string name);
    for (int i = 0; i < 20 && !mem_we_o; i++) @(negedge clk);
    tests++;
    if (!mem_we_o) begin
      fails++;
      $display("FAIL %s_we_timeout: we 0 expected 1", name);
    end
  endtask

  task automatic check_state(input string name);
    check({name, "_count"}, 32'(count_o), 32'(exp_count));
    check({name, "_addr"}, mem_addr_o, BASE + 32'(exp_ptr * 4));
    check({name, "_wraps"}, 32'(wraps_seen), 32'(exp_wraps));
  endtask

  initial begin
    tests = 0; fails = 0;
    exp_ptr = 0; exp_count = 0; exp_wraps = 0; ack_delay = 0;
    rst_i = 1'b0; clr_i = 1'b0; req_valid_i = 1'b0; mem_ack_i = 1'b0;
    op_i = '0; funct3_i = '0; funct7b5_i = 1'b0;
    rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_we",    32'(mem_we_o),    32'd0);
    check("rst_addr",  mem_addr_o,       BASE);
    check("rst_wdata", mem_wdata_o,      32'd0);
    check("rst_count", 32'(count_o),     32'd0);
    check("rst_err",   32'(err_o),       32'd0);
    check("rst_wrap",  32'(wrap_o),      32'd0);
    rst_i = 1'b1;

    // addi x1,x0,5
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    wait_idle("addi");
    check_state("addi");

    // add / sub x3,x1,x2 (imm ignored), sw, beq -4 (wraps), jal 8
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b1, 32'h0020_81B3);
    send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1'b1, 32'h4020_81B3);
    send(3'd3, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2, 32'd8,         1'b1, 32'h0020_A423);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4,       1'b1, 32'hFE20_8EE3);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         1'b1, 32'h0080_00EF);
    wait_idle("seq");
    check_state("seq");
    check("seq_err", 32'(err_o), 32'd0);

    // addi with out-of-range immediate
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'd0);
    wait_idle("range");
    check("range_err", 32'(err_o), 32'd1);
    check_state("range");

    // Stalled ack: monitor checks addr/data every cycle we is high
    ack_delay = 3;
    send(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0113);
    wait_idle("stall");
    ack_delay = 0;

    // lw x5,-4(x2): eighth write, count saturates and pointer wraps again
    send(3'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b1, 32'hFFC1_2283);
    wait_idle("sat");
    check_state("sat");

    // Boundary immediates
    send(3'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h000F_FFFE, 1'b1, 32'h7FFF_F06F);
    send(3'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd2047,      1'b1, 32'h7FF0_0013);
    send(3'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 1'b0, 32'd0);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3,         1'b0, 32'd0);
    wait_idle("bound");
    check_state("bound");
    check("bound_err", 32'(err_o), 32'd1);

    // clr during WR: current write completes, pointer returns to base
    ack_delay = 3;
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0, 1'b1, 32'h0002_80E7);
    wait_we("clr_wr");
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    wait_idle("clr_wr");
    ack_delay = 0;
    exp_ptr = 0;
    exp_count = 0;
    check_state("clr_wr");
    check("clr_wr_err", 32'(err_o), 32'd0);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    wait_idle("after_clr");
    check_state("after_clr");

`ifdef ENC_UTYPE_EN
    send(3'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    send(3'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b0, 32'd0);
`else
    send(3'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'd0);
`endif
    wait_idle("op7");
    check_state("op7");
    check("op7_err", 32'(err_o), 32'd1);

    // clr with valid in IDLE: clear wins, nothing accepted
    @(negedge clk);
    op_i = 3'd1; rd_i = 5'd1; rs1_i = 5'd0; imm_i = 32'd5;
    req_valid_i = 1'b1;
    clr_i = 1'b1;
    #1 check("clr_idle_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    clr_i = 1'b0;
    req_valid_i = 1'b0;
    exp_ptr = 0;
    exp_count = 0;
    repeat (4) @(negedge clk);
    check_state("clr_idle");
    check("clr_idle_err", 32'(err_o), 32'd0);
    check("clr_idle_ready2", 32'(req_ready_o), 32'd1);

    // Reset while a write is stalled
    ack_delay = 5;
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    wait_we("rst_wr");
    #2 rst_i = 1'b0;
    #1;
    check("rstwr_we",    32'(mem_we_o),    32'd0);
    check("rstwr_addr",  mem_addr_o,       BASE);
    check("rstwr_wdata", mem_wdata_o,      32'd0);
    check("rstwr_count", 32'(count_o),     32'd0);
    check("rstwr_err",   32'(err_o),       32'd0);
    check("rstwr_wrap",  32'(wrap_o),      32'd0);
    check("rstwr_ready", 32'(req_ready_o), 32'd1);
    exp_q.delete();
    exp_ptr = 0;
    exp_count = 0;
    ack_delay = 0;
    @(negedge clk);
    wait_cnt = 0;
    rst_i = 1'b1;

    // addi x3,x0,1 after reset
    send(3'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd1, 1'b1, 32'h0010_0193);
    wait_idle("final");
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
